// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of one shared external combinational ALU.
// Define ALU_ARB_ILLEGAL_CHK_EN to flag the reserved function code 3'b011 and zero its result.
module alu_arbiter #(
    parameter int unsigned BW_DATA = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,

    input  logic               i_req0_valid,
    output logic               o_req0_ready,
    input  logic [BW_DATA-1:0] i_req0_a,
    input  logic [BW_DATA-1:0] i_req0_b,
    input  logic [2:0]         i_req0_f,

    input  logic               i_req1_valid,
    output logic               o_req1_ready,
    input  logic [BW_DATA-1:0] i_req1_a,
    input  logic [BW_DATA-1:0] i_req1_b,
    input  logic [2:0]         i_req1_f,

    output logic [BW_DATA-1:0] o_alu_a,
    output logic [BW_DATA-1:0] o_alu_b,
    output logic [2:0]         o_alu_f,
    input  logic [BW_DATA-1:0] i_alu_y,

    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [BW_DATA-1:0] o_rsp_y,
    output logic               o_rsp_id,
    output logic               o_rsp_err,
    output logic               o_busy
);

    localparam int unsigned FW = 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    typedef struct packed {
        logic [BW_DATA-1:0] a;
        logic [BW_DATA-1:0] b;
        logic [FW-1:0]      f;
        logic               id;
    } op_t;

    logic [1:0]         state_q, state_d;
    logic               last_q, last_d;
    op_t                op_q, op_d;
    logic [BW_DATA-1:0] rsp_y_q, rsp_y_d;
    logic               rsp_id_q, rsp_id_d;
    logic               rsp_err_q, rsp_err_d;

    logic               grant0_c;
    logic               grant1_c;
    logic               idle_c;
    logic               accept_c;
    logic               illegal_c;

    // Round-robin pick: a lone requester wins, a tie goes to the one not granted last.
    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            grant0_c = last_q;
            grant1_c = ~last_q;
        end else begin
            grant0_c = i_req0_valid;
            grant1_c = i_req1_valid;
        end
    end

    // Ready is suppressed while reset is asserted so nothing can be accepted on a reset edge.
    assign idle_c       = (state_q == S_IDLE) && !i_rst;
    assign o_req0_ready = idle_c && grant0_c;
    assign o_req1_ready = idle_c && grant1_c;
    assign accept_c     = (o_req0_ready && i_req0_valid) || (o_req1_ready && i_req1_valid);

`ifdef ALU_ARB_ILLEGAL_CHK_EN
    localparam logic [FW-1:0] F_RESERVED = 3'b011;
    assign illegal_c = (op_q.f == F_RESERVED);
`else
    assign illegal_c = 1'b0;
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        op_d      = op_q;
        rsp_y_d   = rsp_y_q;
        rsp_id_d  = rsp_id_q;
        rsp_err_d = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (grant1_c) begin
                        op_d.a = i_req1_a;
                        op_d.b = i_req1_b;
                        op_d.f = i_req1_f;
                    end else begin
                        op_d.a = i_req0_a;
                        op_d.b = i_req0_b;
                        op_d.f = i_req0_f;
                    end
                    op_d.id = grant1_c;
                    last_d  = grant1_c;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_y_d   = illegal_c ? '0 : i_alu_y;
                rsp_id_d  = op_q.id;
                rsp_err_d = illegal_c;
                state_d   = S_RESP;
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Reset drops any in-flight operation without producing a response.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            last_q    <= 1'b1;
            op_q      <= '0;
            rsp_y_q   <= '0;
            rsp_id_q  <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            op_q      <= op_d;
            rsp_y_q   <= rsp_y_d;
            rsp_id_q  <= rsp_id_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign o_alu_a     = op_q.a;
    assign o_alu_b     = op_q.b;
    assign o_alu_f     = op_q.f;
    assign o_rsp_valid = (state_q == S_RESP);
    assign o_rsp_y     = rsp_y_q;
    assign o_rsp_id    = rsp_id_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic against a transaction-level model.
// Honours ALU_ARB_ILLEGAL_CHK_EN the same way the design does.
module tb_alu_arbiter;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
    } op_t;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req0_valid, i_req1_valid;
    logic        o_req0_ready, o_req1_ready;
    logic [31:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
    logic [2:0]  i_req0_f, i_req1_f;
    logic [31:0] o_alu_a, o_alu_b, i_alu_y, o_rsp_y;
    logic [2:0]  o_alu_f;
    logic        o_rsp_valid, i_rsp_ready, o_rsp_id, o_rsp_err, o_busy;

    alu_arbiter #(.BW_DATA(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
        .i_req0_a(i_req0_a), .i_req0_b(i_req0_b), .i_req0_f(i_req0_f),
        .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
        .i_req1_a(i_req1_a), .i_req1_b(i_req1_b), .i_req1_f(i_req1_f),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_f(o_alu_f), .i_alu_y(i_alu_y),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_y(o_rsp_y),
        .o_rsp_id(o_rsp_id), .o_rsp_err(o_rsp_err), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Stand-in for the shared ALU; 3'b011 gets an arbitrary but distinctive result.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        case (f)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b011:  return a + b + 32'h100;
            3'b100:  return a & ~b;
            3'b101:  return a | ~b;
            3'b110:  return a - b;
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    assign i_alu_y = alu_fn(o_alu_a, o_alu_b, o_alu_f);

    function automatic bit ref_err(input logic [2:0] f);
`ifdef ALU_ARB_ILLEGAL_CHK_EN
        return f == 3'b011;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_y(input op_t o);
        return ref_err(o.f) ? 32'd0 : alu_fn(o.a, o.b, o.f);
    endfunction

    // Pending work per requester, the model's view of the arbiter, and DUT observations.
    op_t         q0[$], q1[$];
    int          m_phase;
    bit          m_last;
    op_t         m_op;
    bit          m_id;
    logic [31:0] m_rsp_y;
    bit          m_rsp_id, m_rsp_err;
    int          dut_grant[$], dut_acc_cyc[$], dut_rsp_id[$];
    logic [31:0] dut_rsp_y[$];
    int          cyc, checks, failures;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic op_t rand_op(input bit legal_only);
        op_t o;
        o.a = $urandom;
        o.b = $urandom;
        o.f = 3'($urandom_range(0, 7));
        if (legal_only && o.f == 3'b011) o.f = 3'b010;
        return o;
    endfunction

    // One clock: drive from the queues, compare every output against the model, advance the model.
    task automatic step(input bit rst, input bit rready);
        bit v0, v1, g0, g1;
        i_rst = rst;
        i_rsp_ready = rready;
        v0 = q0.size() != 0;
        v1 = q1.size() != 0;
        i_req0_valid = v0;
        i_req1_valid = v1;
        {i_req0_a, i_req0_b, i_req0_f} = v0 ? q0[0] : '0;
        {i_req1_a, i_req1_b, i_req1_f} = v1 ? q1[0] : '0;
        #1;
        g0 = v0 && (!v1 || m_last);
        g1 = v1 && (!v0 || !m_last);
        check("ready0", 32'(o_req0_ready), 32'(m_phase == 0 && !rst && g0));
        check("ready1", 32'(o_req1_ready), 32'(m_phase == 0 && !rst && g1));
        check("rsp_valid", 32'(o_rsp_valid), 32'(m_phase == 2));
        check("busy", 32'(o_busy), 32'(m_phase != 0));
        check("rsp_y", o_rsp_y, m_rsp_y);
        check("rsp_id", 32'(o_rsp_id), 32'(m_rsp_id));
        check("rsp_err", 32'(o_rsp_err), 32'(m_rsp_err));
        check("alu_a", o_alu_a, m_op.a);
        check("alu_b", o_alu_b, m_op.b);
        check("alu_f", 32'(o_alu_f), 32'(m_op.f));
        if (i_req0_valid && o_req0_ready) begin dut_grant.push_back(0); dut_acc_cyc.push_back(cyc); end
        if (i_req1_valid && o_req1_ready) begin dut_grant.push_back(1); dut_acc_cyc.push_back(cyc); end
        if (o_rsp_valid && i_rsp_ready) begin dut_rsp_y.push_back(o_rsp_y); dut_rsp_id.push_back(int'(o_rsp_id)); end
        @(posedge i_clk);
        cyc++;
        if (rst) begin
            m_phase = 0; m_last = 1'b1; m_op = '0; m_id = 1'b0;
            m_rsp_y = '0; m_rsp_id = 1'b0; m_rsp_err = 1'b0;
        end else if (m_phase == 0) begin
            if (g0 || g1) begin
                m_id = g1;
                m_op = g1 ? q1.pop_front() : q0.pop_front();
                m_last = g1;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_rsp_y = ref_y(m_op);
            m_rsp_id = m_id;
            m_rsp_err = ref_err(m_op.f);
            m_phase = 2;
        end else if (rready) begin
            m_phase = 0;
        end
        @(negedge i_clk);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || m_phase != 0) && n < budget) begin
            step(1'b0, 1'b1);
            n++;
        end
        check("drain_done", 32'(n < budget), 32'd1);
    endtask

    task automatic clear_logs();
        dut_grant.delete(); dut_acc_cyc.delete(); dut_rsp_y.delete(); dut_rsp_id.delete();
    endtask

    initial begin
        int n_rsp;
        checks = 0; failures = 0; cyc = 0;
        m_phase = 0; m_last = 1'b1; m_op = '0; m_id = 1'b0;
        m_rsp_y = '0; m_rsp_id = 1'b0; m_rsp_err = 1'b0;
        i_rst = 1'b1; i_rsp_ready = 1'b1;
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;
        {i_req0_a, i_req0_b, i_req0_f, i_req1_a, i_req1_b, i_req1_f} = '0;
        @(negedge i_clk);
        q0.push_back('{a: 32'd9, b: 32'd9, f: 3'b010});
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        q0.delete();

        // Single op from requester 0.
        q0.push_back('{a: 32'd5, b: 32'd3, f: 3'b010});
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("single_valid", 32'(o_rsp_valid), 32'd1);
        check("single_y", o_rsp_y, 32'd8);
        check("single_id", 32'(o_rsp_id), 32'd0);
        check("single_err", 32'(o_rsp_err), 32'd0);
        drain(20);

        // Simultaneous requests after reset: requester 0 wins the first tie.
        step(1'b1, 1'b1);
        clear_logs();
        q0.push_back('{a: 32'hF0, b: 32'h3C, f: 3'b000});
        q1.push_back('{a: 32'hF0, b: 32'h3C, f: 3'b001});
        drain(20);
        check("simul_count", 32'(dut_rsp_y.size()), 32'd2);
        if (dut_rsp_y.size() == 2) begin
            check("simul_id0", 32'(dut_rsp_id[0]), 32'd0);
            check("simul_y0", dut_rsp_y[0], 32'h30);
            check("simul_id1", 32'(dut_rsp_id[1]), 32'd1);
            check("simul_y1", dut_rsp_y[1], 32'hFC);
        end

        // Backpressure: response held while requester 0 waits.
        clear_logs();
        q1.push_back('{a: 32'd7, b: 32'd9, f: 3'b110});
        step(1'b0, 1'b0);
        q0.push_back('{a: 32'd1, b: 32'd2, f: 3'b010});
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
        check("bp_valid", 32'(o_rsp_valid), 32'd1);
        check("bp_y", o_rsp_y, 32'hFFFF_FFFE);
        check("bp_id", 32'(o_rsp_id), 32'd1);
        check("bp_stalled", 32'(dut_grant.size()), 32'd1);
        drain(20);
        check("bp_order_n", 32'(dut_grant.size()), 32'd2);
        if (dut_grant.size() == 2) check("bp_second", 32'(dut_grant[1]), 32'd0);

        // Saturation: strict alternation at a 3-cycle issue interval.
        step(1'b1, 1'b1);
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(rand_op(1'b1));
            q1.push_back(rand_op(1'b1));
        end
        drain(60);
        check("sat_count", 32'(dut_grant.size()), 32'd8);
        for (int i = 0; i < 6 && i < dut_grant.size(); i++) begin
            check("sat_order", 32'(dut_grant[i]), 32'(i % 2));
            if (i > 0) check("sat_interval", 32'(dut_acc_cyc[i] - dut_acc_cyc[i-1]), 32'd3);
        end

        // Reset in EXEC discards the operation.
        clear_logs();
        q0.push_back('{a: 32'h1234, b: 32'h4321, f: 3'b001});
        step(1'b0, 1'b1);
        check("rst_in_exec", 32'(o_busy), 32'd1);
        step(1'b1, 1'b1);
        check("rst_valid", 32'(o_rsp_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_alu_a", o_alu_a, 32'd0);
        check("rst_alu_b", o_alu_b, 32'd0);
        check("rst_alu_f", 32'(o_alu_f), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        check("rst_no_rsp", 32'(dut_rsp_y.size()), 32'd0);

        // Reserved function code.
        q0.push_back('{a: 32'd1, b: 32'd1, f: 3'b011});
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
`ifdef ALU_ARB_ILLEGAL_CHK_EN
        check("illegal_err", 32'(o_rsp_err), 32'd1);
        check("illegal_y", o_rsp_y, 32'd0);
`else
        check("illegal_err", 32'(o_rsp_err), 32'd0);
        check("illegal_y", o_rsp_y, 32'h102);
`endif
        drain(20);

        // Random traffic, backpressure and occasional reset.
        clear_logs();
        for (int i = 0; i < 500; i++) begin
            if (q0.size() < 3 && $urandom_range(0, 99) < 40) q0.push_back(rand_op(1'b0));
            if (q1.size() < 3 && $urandom_range(0, 99) < 40) q1.push_back(rand_op(1'b0));
            step(1'b0 || ($urandom_range(0, 99) < 2), $urandom_range(0, 99) < 70);
        end
        n_rsp = dut_rsp_y.size();
        check("rand_progress", 32'(n_rsp > 20), 32'd1);
        drain(60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
